idex_pipe_reg: RTL

Parametrised ID/EX pipeline register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and stall/bubble performance counters. It sits between decode and execute in the five-stage core, and is the drop-in successor to the fixed-width, always-advancing ID/EX latch. It lets hazard logic stall or flush the stage without inserting combinational ready paths back into decode.

---
 rtl/idex_pipe_reg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: two-entry skid buffer between decode and execute,
// with flush and saturating stall/bubble counters.
module idex_pipe_reg #(
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int EX_W   = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [EX_W-1:0]   EX,
  input  logic [DATA_W-1:0] regRs,
  input  logic [DATA_W-1:0] regRt,
  input  logic [DATA_W-1:0] imm_value,
  input  logic [DATA_W-1:0] PC,
  input  logic [ADDR_W-1:0] addrRs,
  input  logic [ADDR_W-1:0] addrRt,
  input  logic [ADDR_W-1:0] addrRd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WBOut,
  output logic [M_W-1:0]    MOut,
  output logic [EX_W-1:0]   EXOut,
  output logic [DATA_W-1:0] regRsOut,
  output logic [DATA_W-1:0] regRtOut,
  output logic [DATA_W-1:0] imm_valueOut,
  output logic [DATA_W-1:0] PCOut,
  output logic [ADDR_W-1:0] addrRsOut,
  output logic [ADDR_W-1:0] addrRtOut,
  output logic [ADDR_W-1:0] addrRdOut,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [EX_W-1:0]   ex;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] ars;
    logic [ADDR_W-1:0] art;
    logic [ADDR_W-1:0] ard;
  } bundle_t;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  bundle_t          in_b;
  bundle_t          o_q, o_d;
  bundle_t          s_q, s_d;
  logic             o_v, o_vd;
  logic             s_v, s_vd;
  logic             acc, drn;
  logic [CNT_W-1:0] stall_q, bubble_q;

  assign in_b = '{wb: WB, m: M, ex: EX,
                  rs: regRs, rt: regRt,
                  imm: imm_value, pc: PC,
                  ars: addrRs, art: addrRt,
                  ard: addrRd};

  assign in_ready = !s_v;
  assign acc = in_valid && in_ready;
  assign drn = o_v && out_ready;

  // S only fills while O is held, so O is never empty with S valid
  always_comb begin
    o_d  = o_q;
    s_d  = s_q;
    o_vd = o_v;
    s_vd = s_v;
    if (flush) begin
      o_vd = 1'b0;
      s_vd = 1'b0;
    end else if (!o_v || drn) begin
      if (s_v) begin
        o_d  = s_q;
        o_vd = 1'b1;
        s_vd = 1'b0;
      end else if (acc) begin
        o_d  = in_b;
        o_vd = 1'b1;
      end else begin
        o_vd = 1'b0;
      end
    end else if (acc) begin
      s_d  = in_b;
      s_vd = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_v      <= 1'b0;
      s_v      <= 1'b0;
      o_q      <= '0;
      s_q      <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      o_v <= o_vd;
      s_v <= s_vd;
      o_q <= o_d;
      s_q <= s_d;
      if (o_v && !out_ready && stall_q != CMAX)
        stall_q <= stall_q + 1'b1;
      if (!o_v && bubble_q != CMAX)
        bubble_q <= bubble_q + 1'b1;
    end
  end

  // empty O presents a NOP; data fields keep their last value
  assign out_valid    = o_v;
  assign WBOut        = o_v ? o_q.wb : '0;
  assign MOut         = o_v ? o_q.m  : '0;
  assign EXOut        = o_v ? o_q.ex : '0;
  assign regRsOut     = o_q.rs;
  assign regRtOut     = o_q.rt;
  assign imm_valueOut = o_q.imm;
  assign PCOut        = o_q.pc;
  assign addrRsOut    = o_q.ars;
  assign addrRtOut    = o_q.art;
  assign addrRdOut    = o_q.ard;
  assign stall_cnt    = stall_q;
  assign bubble_cnt   = bubble_q;

endmodule
